// File: rtl/hazard_fwd_scoreboard_pkg.sv
// Shared constants for the ID-stage hazard/forwarding unit.
// Forward-select encodings and E/M shadow-record field widths.
package hazard_pkg;

    typedef logic [2:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 3'd0;
    localparam fwd_sel_t FWD_EXE = 3'd1;
    localparam fwd_sel_t FWD_MEM = 3'd2;
    localparam fwd_sel_t FWD_LW  = 3'd3;
    localparam fwd_sel_t FWD_MC  = 3'd4;

    localparam int SH_WREG_W  = 1;
    localparam int SH_M2REG_W = 1;

endpackage

// File: rtl/hazard_fwd_scoreboard_if.sv
// ID-stage request / hazard-response bundle of hazard_fwd_scoreboard.
// master drives the decoded instruction, slave returns stall/forward info.
interface hazard_fwd_scoreboard_if #(
    parameter int RW = 5
);
    import hazard_pkg::*;

    logic          id_valid;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic          id_wreg;
    logic [RW-1:0] id_rn;
    logic          id_m2reg;
    logic          id_mc;

    logic          stall;
    logic          issue;
    fwd_sel_t      fwda;
    fwd_sel_t      fwdb;
    logic          mc_start;
    logic          mc_busy;
    logic          mc_done;
    logic [RW-1:0] mc_rn;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        output id_wreg, id_rn, id_m2reg, id_mc,
        input  stall, issue, fwda, fwdb,
        input  mc_start, mc_busy, mc_done, mc_rn
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        input  id_wreg, id_rn, id_m2reg, id_mc,
        output stall, issue, fwda, fwdb,
        output mc_start, mc_busy, mc_done, mc_rn
    );

endinterface

// File: rtl/hazard_fwd_scoreboard_mc_scoreboard.sv
// Tracks the single outstanding multi-cycle (mul/div) operation.
// Produces mc_done and the RAW/WAW/structural stall terms against it.
module mc_scoreboard
    import hazard_pkg::*;
#(
    parameter int RW     = 5,
    parameter int MC_LAT = 4,
    parameter int CW     = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          issue,
    input  logic          id_mc,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic          id_wreg,
    input  logic [RW-1:0] id_rn,
    output logic          busy_o,
    output logic          done_o,
    output logic [RW-1:0] rn_o,
    output logic          hit_a_o,
    output logic          hit_b_o,
    output logic          stall_o
);

    logic          pending_q, pending_d;
    logic [RW-1:0] rn_q, rn_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done;
    logic          pend_nd;
    logic          waw;

    always_comb begin
        done    = pending_q & (cnt_q == CW'(1));
        pend_nd = pending_q & ~done;
        hit_a_o = pending_q & id_use_rs & (id_rs != '0) & (id_rs == rn_q);
        hit_b_o = pending_q & id_use_rt & (id_rt != '0) & (id_rt == rn_q);
        waw     = id_wreg & (id_rn != '0) & (id_rn == rn_q);
        stall_o = pend_nd & (hit_a_o | hit_b_o | waw | id_mc);
        busy_o  = pending_q;
        done_o  = done & ~reset;
        rn_o    = rn_q;
    end

    // A new op may start in the done cycle, so issue overrides retirement.
    always_comb begin
        pending_d = pending_q;
        rn_d      = rn_q;
        cnt_d     = cnt_q;
        if (pending_q) begin
            cnt_d = cnt_q - CW'(1);
            if (done) begin
                pending_d = 1'b0;
                cnt_d     = '0;
            end
        end
        if (issue & id_mc) begin
            pending_d = 1'b1;
            rn_d      = id_rn;
            cnt_d     = CW'(MC_LAT);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q <= 1'b0;
            rn_q      <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            rn_q      <= rn_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/hazard_fwd_scoreboard.sv
// ID-stage hazard detection and operand forwarding with a mul/div scoreboard.
// Define HAZ_FORWARD_EN for bypassing; otherwise every RAW hazard stalls.
module hazard_fwd_scoreboard
    import hazard_pkg::*;
#(
    parameter int RW     = 5,
    parameter int MC_LAT = 4,
    parameter int CW     = 4
) (
    input  logic clock,
    input  logic reset,
    hazard_fwd_scoreboard_if.slave bus
);

    logic [SH_WREG_W-1:0]  e_wreg_q, e_wreg_d, m_wreg_q, m_wreg_d;
    logic [RW-1:0]         e_rn_q, e_rn_d, m_rn_q, m_rn_d;
    logic [SH_M2REG_W-1:0] e_m2reg_q, e_m2reg_d;

    logic          stall, issue, haz, load_use, e_go;
    logic          e_hit_a, e_hit_b, m_hit_a, m_hit_b;
    logic          mc_busy, mc_done, mc_hit_a, mc_hit_b, mc_stall;
    logic [RW-1:0] mc_rn;

    function automatic logic hit(input logic use_x, input logic [RW-1:0] x,
                                 input logic wreg, input logic [RW-1:0] rn);
        return use_x & (x != '0) & wreg & (rn == x);
    endfunction

    mc_scoreboard #(.RW(RW), .MC_LAT(MC_LAT), .CW(CW)) u_mc (
        .clock     (clock),
        .reset     (reset),
        .issue     (issue),
        .id_mc     (bus.id_mc),
        .id_rs     (bus.id_rs),
        .id_rt     (bus.id_rt),
        .id_use_rs (bus.id_use_rs),
        .id_use_rt (bus.id_use_rt),
        .id_wreg   (bus.id_wreg),
        .id_rn     (bus.id_rn),
        .busy_o    (mc_busy),
        .done_o    (mc_done),
        .rn_o      (mc_rn),
        .hit_a_o   (mc_hit_a),
        .hit_b_o   (mc_hit_b),
        .stall_o   (mc_stall)
    );

    always_comb begin
        e_hit_a  = hit(bus.id_use_rs, bus.id_rs, e_wreg_q[0], e_rn_q);
        e_hit_b  = hit(bus.id_use_rt, bus.id_rt, e_wreg_q[0], e_rn_q);
        m_hit_a  = hit(bus.id_use_rs, bus.id_rs, m_wreg_q[0], m_rn_q);
        m_hit_b  = hit(bus.id_use_rt, bus.id_rt, m_wreg_q[0], m_rn_q);
        load_use = e_m2reg_q[0] & (e_hit_a | e_hit_b);
`ifdef HAZ_FORWARD_EN
        haz = load_use | mc_stall;
`else
        haz = load_use | mc_stall | e_hit_a | e_hit_b | m_hit_a | m_hit_b
            | mc_hit_a | mc_hit_b;
`endif
        stall = ~reset & bus.id_valid & haz;
        issue = ~reset & bus.id_valid & ~stall;
    end

    // Multi-cycle ops retire through the scoreboard, not the E/M shadows.
    always_comb begin
        e_go      = issue & ~bus.id_mc;
        e_wreg_d  = SH_WREG_W'(e_go & bus.id_wreg);
        e_rn_d    = e_go ? bus.id_rn : '0;
        e_m2reg_d = SH_M2REG_W'(e_go & bus.id_m2reg);
        m_wreg_d  = e_wreg_q;
        m_rn_d    = e_rn_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            e_wreg_q  <= '0;
            e_rn_q    <= '0;
            e_m2reg_q <= '0;
            m_wreg_q  <= '0;
            m_rn_q    <= '0;
        end else begin
            e_wreg_q  <= e_wreg_d;
            e_rn_q    <= e_rn_d;
            e_m2reg_q <= e_m2reg_d;
            m_wreg_q  <= m_wreg_d;
            m_rn_q    <= m_rn_d;
        end
    end

`ifdef HAZ_FORWARD_EN
    logic [SH_M2REG_W-1:0] m_m2reg_q, m_m2reg_d;

    always_comb m_m2reg_d = e_m2reg_q;

    always_ff @(posedge clock) begin
        if (reset) m_m2reg_q <= '0;
        else       m_m2reg_q <= m_m2reg_d;
    end

    function automatic fwd_sel_t pick(input logic e_hit, input logic e_ld,
                                      input logic m_hit, input logic m_ld,
                                      input logic mc_hit);
        fwd_sel_t sel;
        priority case (1'b1)
            e_hit & ~e_ld: sel = FWD_EXE;
            m_hit & ~m_ld: sel = FWD_MEM;
            m_hit & m_ld:  sel = FWD_LW;
            mc_hit:        sel = FWD_MC;
            default:       sel = FWD_RF;
        endcase
        return sel;
    endfunction

    always_comb begin
        bus.fwda = reset ? FWD_RF : pick(e_hit_a, e_m2reg_q[0], m_hit_a,
                                         m_m2reg_q[0], mc_done & mc_hit_a);
        bus.fwdb = reset ? FWD_RF : pick(e_hit_b, e_m2reg_q[0], m_hit_b,
                                         m_m2reg_q[0], mc_done & mc_hit_b);
    end
`else
    always_comb begin
        bus.fwda = FWD_RF;
        bus.fwdb = FWD_RF;
    end
`endif

    always_comb begin
        bus.stall    = stall;
        bus.issue    = issue;
        bus.mc_start = issue & bus.id_mc;
        bus.mc_busy  = mc_busy;
        bus.mc_done  = mc_done;
        bus.mc_rn    = mc_rn;
    end

endmodule
